// File: rtl/top2_pkg.sv
// Shared constants, channel state type and round-robin helper for the top-2 scheduler.
// Optional per-channel sample counting is enabled with TOP2_SAMPLE_COUNT_EN.
package top2_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_CH     = 4;

    // Per-channel state at the default sample width.
    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] largest;
        logic [DEFAULT_DATA_WIDTH-1:0] second;
    } ch_state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_ch);
        return (idx + 1 >= num_ch) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/top2_update.sv
// Combinational largest/second-largest update; one instance is time-shared by all channels.
module top2_update
    import top2_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] largest_i,
    input  logic [DATA_WIDTH-1:0] second_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] largest_o,
    output logic [DATA_WIDTH-1:0] second_o
);

    // Strict compares: a repeat of the current largest still lands in second.
    always_comb begin
        largest_o = largest_i;
        second_o  = second_i;
        if (d_i > largest_i) begin
            largest_o = d_i;
            second_o  = largest_i;
        end else if (d_i > second_i) begin
            second_o = d_i;
        end
    end

endmodule

// File: rtl/top2_rr_scheduler.sv
// Round-robin scheduler sharing one top-2 update unit across NUM_CH sample streams.
// Define TOP2_SAMPLE_COUNT_EN to add per-channel sample counters and the rd_ready output.
module top2_rr_scheduler
    import top2_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_CH     = DEFAULT_NUM_CH,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            clr,
    input  logic [CH_W-1:0]              rd_sel,
    output logic [DATA_WIDTH-1:0]        rd_second,
    output logic [CH_W-1:0]              grant_id,
    output logic                         grant_vld
`ifdef TOP2_SAMPLE_COUNT_EN
    ,
    output logic                         rd_ready
`endif
);

    // Handshake: a sample on channel i transfers at the rising edge where
    // req_valid[i] && req_ready[i]; at most one ready bit is high per cycle.

    logic [DATA_WIDTH-1:0] sample [NUM_CH];
    logic [DATA_WIDTH-1:0] largest_q [NUM_CH];
    logic [DATA_WIDTH-1:0] largest_d [NUM_CH];
    logic [DATA_WIDTH-1:0] second_q  [NUM_CH];
    logic [DATA_WIDTH-1:0] second_d  [NUM_CH];

    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] rd_second_q, rd_second_d;
    logic [CH_W-1:0]       grant_id_q, grant_id_d;
    logic                  grant_vld_q, grant_vld_d;

    logic [NUM_CH-1:0]     eligible;
    logic                  accept;
    logic [CH_W-1:0]       grant_idx;
    logic [CH_W-1:0]       cand;
    int                    idx;

    logic [DATA_WIDTH-1:0] upd_largest, upd_second;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign sample[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // A channel being cleared is masked so its pending sample simply waits.
    always_comb begin
        eligible  = req_valid & ~clr;
        req_ready = '0;
        accept    = 1'b0;
        grant_idx = '0;
        cand      = '0;
        idx       = 0;
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                cand = CH_W'(idx);
                if (!accept && eligible[cand]) begin
                    accept    = 1'b1;
                    grant_idx = cand;
                end
            end
            if (accept) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    top2_update #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_update (
        .largest_i (largest_q[grant_idx]),
        .second_i  (second_q[grant_idx]),
        .d_i       (sample[grant_idx]),
        .largest_o (upd_largest),
        .second_o  (upd_second)
    );

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            largest_d[i] = largest_q[i];
            second_d[i]  = second_q[i];
            if (clr[i]) begin
                largest_d[i] = '0;
                second_d[i]  = '0;
            end else if (accept && grant_idx == CH_W'(i)) begin
                largest_d[i] = upd_largest;
                second_d[i]  = upd_second;
            end
        end
        ptr_d       = accept ? CH_W'(rr_next(32'(grant_idx), NUM_CH)) : ptr_q;
        grant_vld_d = accept;
        grant_id_d  = accept ? grant_idx : grant_id_q;
        // Readout samples the settled register, so it trails an update by one edge.
        rd_second_d = (32'(rd_sel) < NUM_CH) ? second_q[rd_sel] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                largest_q[i] <= '0;
                second_q[i]  <= '0;
            end
            ptr_q       <= '0;
            rd_second_q <= '0;
            grant_id_q  <= '0;
            grant_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                largest_q[i] <= largest_d[i];
                second_q[i]  <= second_d[i];
            end
            ptr_q       <= ptr_d;
            rd_second_q <= rd_second_d;
            grant_id_q  <= grant_id_d;
            grant_vld_q <= grant_vld_d;
        end
    end

    assign rd_second = rd_second_q;
    assign grant_id  = grant_id_q;
    assign grant_vld = grant_vld_q;

`ifdef TOP2_SAMPLE_COUNT_EN
    // Saturating count: 0, 1, then 2 meaning "second is a real sample".
    logic [1:0] cnt_q [NUM_CH];
    logic [1:0] cnt_d [NUM_CH];
    logic       rd_ready_q, rd_ready_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr[i]) begin
                cnt_d[i] = 2'd0;
            end else if (accept && grant_idx == CH_W'(i) && cnt_q[i] != 2'd2) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end
        end
        rd_ready_d = (32'(rd_sel) < NUM_CH) ? (cnt_q[rd_sel] == 2'd2) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= 2'd0;
            end
            rd_ready_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rd_ready_q <= rd_ready_d;
        end
    end

    assign rd_ready = rd_ready_q;
`endif

endmodule
